multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle successor to the single-cycle MIPS control decoder. A state machine sequences each instruction over 3–5+ cycles and drives a shared-memory multi-cycle datapath (single memory, IR, A/B/ALUOut/MDR registers). It adds three things to the decoder's instruction set: a variable-latency memory handshake with a timeout, illegal-opcode trapping, and a retired-instruction counter. It sits between the IR opcode field and the datapath mux/enable inputs.

## Interface
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT, 16, max cycles waiting on mem_ready before error; 0 disables timeout
- HAS_EXT, 1, 1 = ori/lui/j/jal legal; 0 = those opcodes trap as illegal

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepts write / returns read data this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (valid with mem_req)
- iord  out  1  0 = PC address, 1 = ALUOut address
- ir_write  out  1  load IR from memory data
- pc_en  out  1  PC write enable (unconditional, or branch taken)
- pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- regdst  out  2  00 rt, 01 rd, 10 $31
- memtoreg  out  2  00 ALUOut, 01 MDR, 10 PC (link)
- regwrite  out  1  register-file write
- alusrca  out  1  0 PC, 1 A
- alusrcb  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- aluop  out  2  00 add, 01 sub, 10 funct, 11 or
- zero_ext  out  1  immediate zero-extended (ori)
- lui_sel  out  1  ALU result replaced by imm<<16
- illegal  out  1  one-cycle pulse on trapped opcode
- err  out  1  sticky memory-timeout error
- instr_count  out  CNT_W  retired legal instructions

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, ILLEGAL, ERROR.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00. Holds until mem_ready; on that cycle ir_write=1, pc_en=1, then goes to DECODE.
- DECODE: alusrcb=11, aluop=00 (branch target into ALUOut). Dispatch on opcode:
  - lw/sw -> MEM_ADDR
  - R -> R_EXEC
  - beq -> BRANCH
  - ori/lui -> I_EXEC
  - j/jal -> JUMP
  - else -> ILLEGAL
- MEM_ADDR: alusrca=1, alusrcb=10. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_req=1, iord=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: regwrite=1, regdst=00, memtoreg=01.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Holds until mem_ready.
- R_EXEC: alusrca=1, alusrcb=00, aluop=10.
- R_WB: regwrite=1, regdst=01, memtoreg=00.
- I_EXEC: alusrca=1, alusrcb=10, aluop=11, zero_ext=1; lui_sel=1 when lui.
- I_WB: regwrite=1, regdst=00, memtoreg=00.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pc_en=zero.
- JUMP: pcsource=10, pc_en=1; for jal also regwrite=1, regdst=10, memtoreg=10 (PC already +4).
- ILLEGAL: illegal=1, no writes.
- Terminal states return to FETCH: MEM_WB, MEM_WR (on ready), R_WB, I_WB, BRANCH, JUMP, ILLEGAL.
- instr_count increments on the final cycle of each legal instruction (taken or not-taken beq included). Never increments on ILLEGAL. Wraps modulo 2^CNT_W.
- Timeout: a counter clears on entry to each waiting state (FETCH, MEM_RD, MEM_WR) and counts cycles with mem_ready=0. At count TIMEOUT-1 with mem_ready still 0, the next state is ERROR. If mem_ready=1 on that same cycle, ready wins.
- ERROR: err=1, all enables and mem_req 0. Held until reset.
- Unassigned outputs default to 0 in every state.

## Timing
- Outputs are combinational from registered state plus opcode/zero/mem_ready. No output register.
- Zero-wait cycle counts: beq/j/jal 3, R/ori/lui/sw 4, lw 5. Each wait cycle adds 1.
- mem_req stays high every cycle of a waiting state until the mem_ready cycle, and is low the following cycle.
- While reset=1, every enable, mem_req, illegal and err is forced 0. On the first edge with reset=1: state=FETCH, counters=0, err=0.
- Reset mid-access abandons the access with no write. mem_req drops in the same cycle reset is asserted.

## Structure
- Shared package `mctl_pkg`: opcode constants, state encoding, aluop/pcsource/regdst/memtoreg/alusrcb encodings.
- One sub-module, `mem_wait_timer`: clear, count, and expired outputs; parameter TIMEOUT.

## Test plan
- add (op 000000), zero wait -> states FETCH, DECODE, R_EXEC, R_WB; regwrite with regdst=01 on cycle 4; instr_count 0 -> 1.
- lw with mem_ready low 3 cycles in MEM_RD -> mem_req high 4 cycles there; total 8 cycles; regwrite with memtoreg=01 on the last.
- beq with zero=0, then zero=1 -> pc_en low, then high in BRANCH; both retire (count +2).
- opcode 111111 (and ori with HAS_EXT=0) -> illegal pulses 1 cycle, no regwrite/pc_en, count unchanged, back in FETCH.
- TIMEOUT=4, mem_ready stuck low in FETCH -> ERROR after 4 cycles, err=1 sticky. mem_ready rising on the 4th cycle instead -> no error, DECODE.
- jal then reset asserted during a stalled FETCH -> jal writes $31 with memtoreg=10; under reset mem_req drops the same cycle, err and count read 0 after reset.

Source files
------------

// File: rtl/mctl_pkg.sv
// rtl/mctl_pkg.sv - shared opcodes, state encoding and datapath select encodings
package mctl_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXEC,
    S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL, S_ERROR
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // States that stall on the memory handshake and are guarded by the timer.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - cycle counter bounding how long a memory wait may stall
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : restart the count (asserted on any state change)
//   count        : one more cycle spent waiting without mem_ready
//   expired      : count has reached TIMEOUT-1; never set when TIMEOUT is 0
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  // Saturates at the expiry value so a long legal wait cannot wrap.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = (cnt == W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory timeout, trap and retire count
//
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   opcode, zero         : IR[31:26] (valid from DECODE on) and ALU zero flag
//   mem_ready            : memory completes the current request this cycle
//   mem_req, mem_we, iord: memory request, write strobe, address select
//   ir_write, pc_en      : IR load and PC write enables
//   pcsource, regdst, memtoreg, regwrite : PC / register-file write path
//   alusrca, alusrcb, aluop, zero_ext, lui_sel : ALU operand and function selects
//   illegal              : one-cycle pulse for a trapped opcode
//   err                  : sticky memory-timeout error
//   instr_count          : retired legal instructions, wraps
module multicycle_control
  import mctl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter bit HAS_EXT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pcsource,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             zero_ext,
  output logic             lui_sel,
  output logic             illegal,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  state_t state, state_next;
  logic   retire;
  logic   expired;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Any state change restarts the wait budget, so each waiting state begins at zero.
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_next != state),
    .count   (is_wait_state(state) && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pcsource   = PC_ALU;
    regdst     = RD_RT;
    memtoreg   = M2R_ALUOUT;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    aluop      = ALU_ADD;
    zero_ext   = 1'b0;
    lui_sel    = 1'b0;
    illegal    = 1'b0;
    err        = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        // A ready on the expiry cycle still completes the fetch.
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_en      = 1'b1;
          state_next = S_DECODE;
        end else if (expired) begin
          state_next = S_ERROR;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:   state_next = S_MEM_ADDR;
          OP_R:           state_next = S_R_EXEC;
          OP_BEQ:         state_next = S_BRANCH;
          OP_ORI, OP_LUI: state_next = HAS_EXT ? S_I_EXEC : S_ILLEGAL;
          OP_J, OP_JAL:   state_next = HAS_EXT ? S_JUMP : S_ILLEGAL;
          default:        state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_next = S_MEM_WB;
        end else if (expired) begin
          state_next = S_ERROR;
        end
      end
      S_MEM_WB: begin
        regwrite   = 1'b1;
        memtoreg   = M2R_MDR;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (expired) begin
          state_next = S_ERROR;
        end
      end
      S_R_EXEC: begin
        alusrca    = 1'b1;
        aluop      = ALU_FUNCT;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        regwrite   = 1'b1;
        regdst     = RD_RD;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_I_EXEC: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        aluop      = ALU_OR;
        zero_ext   = 1'b1;
        lui_sel    = (opcode == OP_LUI);
        state_next = S_I_WB;
      end
      S_I_WB: begin
        regwrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = ALU_SUB;
        pcsource   = PC_ALUOUT;
        pc_en      = zero;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pcsource = PC_JUMP;
        pc_en    = 1'b1;
        // PC was already advanced by 4 in FETCH, so it is the link value.
        if (opcode == OP_JAL) begin
          regwrite = 1'b1;
          regdst   = RD_RA;
          memtoreg = M2R_PC;
        end
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        state_next = S_FETCH;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // Reset abandons any access in the same cycle it is asserted.
    if (reset) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ir_write = 1'b0;
      pc_en    = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
      err      = 1'b0;
      retire   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  localparam int TO = 4;

  localparam logic [5:0] OPC_R   = 6'b000000;
  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_ORI = 6'b001101;
  localparam logic [5:0] OPC_LUI = 6'b001111;
  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;
  localparam logic [5:0] OPC_BAD = 6'b111111;

  typedef struct {
    logic [5:0] op;
    int         z;
    int         fw;
    int         mw;
  } instr_t;

  typedef struct {
    int         len;
    int         n_rw;
    logic [1:0] regdst;
    logic [1:0] m2r;
    int         n_pc;
    int         n_ill;
    int         n_wr;
    int         n_dreq;
    int         n_lui;
    int         cnt;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_en, regwrite, alusrca;
  logic        zero_ext, lui_sel, illegal, err;
  logic [1:0]  pcsource, regdst, memtoreg, alusrcb, aluop;
  logic [31:0] instr_count;

  logic        mem_req2, mem_we2, iord2, ir_write2, pc_en2, regwrite2, alusrca2;
  logic        zero_ext2, lui_sel2, illegal2, err2;
  logic [1:0]  pcsource2, regdst2, memtoreg2, alusrcb2, aluop2;
  logic [31:0] instr_count2;

  logic        drv_en = 1'b0;
  logic        mon_en = 1'b0;
  logic        drv_ready = 1'b0, dir_ready = 1'b0;
  logic [5:0]  drv_op = '0, dir_op = '0;
  logic        drv_z = 1'b0, dir_z = 1'b0;

  assign mem_ready = drv_en ? drv_ready : dir_ready;
  assign opcode    = drv_en ? drv_op : dir_op;
  assign zero      = drv_en ? drv_z : dir_z;

  int     total = 0;
  int     bad = 0;
  instr_t prog[$];
  rec_t   sb[$];
  rec_t   acc;
  int     model_cnt = 0;
  int     cur = 0, nxt = 0, wcnt = 0, k = 0;
  bit     have_prev = 0, err_seen = 0;

  always #5 clock = ~clock;

  multicycle_control #(.CNT_W(32), .TIMEOUT(TO), .HAS_EXT(1'b1)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pcsource(pcsource), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .zero_ext(zero_ext),
    .lui_sel(lui_sel), .illegal(illegal), .err(err), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(32), .TIMEOUT(TO), .HAS_EXT(1'b0)) dut2 (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req2), .mem_we(mem_we2), .iord(iord2), .ir_write(ir_write2), .pc_en(pc_en2),
    .pcsource(pcsource2), .regdst(regdst2), .memtoreg(memtoreg2), .regwrite(regwrite2),
    .alusrca(alusrca2), .alusrcb(alusrcb2), .aluop(aluop2), .zero_ext(zero_ext2),
    .lui_sel(lui_sel2), .illegal(illegal2), .err(err2), .instr_count(instr_count2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Instruction-level reference: cycles from its IR load to the next IR load,
  // plus the control events the instruction must produce along the way.
  function automatic rec_t model(instr_t it, int next_fw);
    rec_t r;
    int   body;
    bit   legal;
    r = '{default: 0};
    body = 2;
    legal = 1;
    case (it.op)
      OPC_R:   begin body = 3; r.n_rw = 1; r.regdst = 2'b01; end
      OPC_LW:  begin body = 4 + it.mw; r.n_rw = 1; r.m2r = 2'b01; r.n_dreq = it.mw + 1; end
      OPC_SW:  begin body = 3 + it.mw; r.n_wr = 1; r.n_dreq = it.mw + 1; end
      OPC_BEQ: begin body = 2; r.n_pc = it.z; end
      OPC_ORI: begin body = 3; r.n_rw = 1; end
      OPC_LUI: begin body = 3; r.n_rw = 1; r.n_lui = 1; end
      OPC_J:   begin body = 2; r.n_pc = 1; end
      OPC_JAL: begin body = 2; r.n_pc = 1; r.n_rw = 1; r.regdst = 2'b10; r.m2r = 2'b10; end
      default: begin body = 2; legal = 0; r.n_ill = 1; end
    endcase
    r.len = body + next_fw + 1;
    if (legal) model_cnt++;
    r.cnt = model_cnt;
    return r;
  endfunction

  task automatic close_rec();
    rec_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check($sformatf("len#%0d", k), acc.len, e.len);
      check($sformatf("regwrite#%0d", k), acc.n_rw, e.n_rw);
      check($sformatf("regdst#%0d", k), acc.regdst, e.regdst);
      check($sformatf("memtoreg#%0d", k), acc.m2r, e.m2r);
      check($sformatf("pc_en#%0d", k), acc.n_pc, e.n_pc);
      check($sformatf("illegal#%0d", k), acc.n_ill, e.n_ill);
      check($sformatf("memwrite#%0d", k), acc.n_wr, e.n_wr);
      check($sformatf("datareq#%0d", k), acc.n_dreq, e.n_dreq);
      check($sformatf("lui_sel#%0d", k), acc.n_lui, e.n_lui);
      check($sformatf("count#%0d", k), instr_count, e.cnt);
    end
    k++;
  endtask

  // Memory stub: answers each request after the wait its instruction asks for.
  always @(negedge clock) begin
    int need;
    if (drv_en) begin
      if (mem_req) begin
        need = iord ? prog[cur].mw : prog[nxt].fw;
        if (wcnt >= need) begin
          drv_ready = 1'b1;
          wcnt = 0;
          if (!iord) begin
            cur = nxt;
            nxt++;
            drv_op = prog[cur].op;
            drv_z = prog[cur].z[0];
            sb.push_back(model(prog[cur], prog[nxt].fw));
          end
        end else begin
          drv_ready = 1'b0;
          wcnt++;
        end
      end else begin
        drv_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  always @(negedge clock) begin
    #1;
    if (mon_en && !err_seen) begin
      if (err) begin
        err_seen = 1;
        if (have_prev) close_rec();
      end else begin
        if (ir_write) begin
          if (have_prev) close_rec();
          acc = '{default: 0};
          have_prev = 1;
        end
        acc.len++;
        if (regwrite) begin
          acc.n_rw++;
          acc.regdst = regdst;
          acc.m2r = memtoreg;
        end
        if (pc_en && !ir_write) acc.n_pc++;
        if (illegal) acc.n_ill++;
        if (mem_req && mem_we && mem_ready) acc.n_wr++;
        if (mem_req && iord) acc.n_dreq++;
        if (lui_sel) acc.n_lui++;
      end
    end
  end

  initial begin
    logic [5:0] ops [0:8];
    int guard;
    ops = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_ORI, OPC_LUI, OPC_J, OPC_JAL, OPC_BAD};
    prog.push_back('{OPC_R, 0, 0, 0});
    prog.push_back('{OPC_LW, 0, 0, 3});
    prog.push_back('{OPC_BEQ, 0, 0, 0});
    prog.push_back('{OPC_BEQ, 1, 1, 0});
    prog.push_back('{OPC_BAD, 0, 0, 0});
    prog.push_back('{OPC_JAL, 0, 0, 0});
    prog.push_back('{OPC_ORI, 0, 3, 0});
    prog.push_back('{OPC_SW, 0, 2, 1});
    prog.push_back('{OPC_LUI, 0, 0, 0});
    prog.push_back('{OPC_J, 0, 0, 0});
    for (int i = 0; i < 40; i++) begin
      instr_t it;
      int sel;
      sel = $urandom_range(0, 9);
      it.op = (sel == 9) ? 6'($urandom_range(0, 63)) : ops[sel];
      it.z = $urandom_range(0, 1);
      it.fw = $urandom_range(0, TO - 1);
      it.mw = $urandom_range(0, TO - 1);
      prog.push_back(it);
    end
    prog.push_back('{OPC_R, 0, TO, 0});

    reset = 1'b1;
    @(negedge clock); #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_err", err, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_count", instr_count, 0);

    @(posedge clock); #1;
    reset = 1'b0;
    drv_en = 1'b1;
    mon_en = 1'b1;

    guard = 0;
    while (!err_seen && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    #2;
    check("timeout_reached", err_seen, 1);
    drv_en = 1'b0;
    mon_en = 1'b0;
    check("sb_drained", sb.size(), 0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      check("err_sticky", err, 1);
      check("err_mem_req", mem_req, 0);
    end

    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_err_forced", err, 0);
    @(negedge clock); #1;
    check("reset_count", instr_count, 0);

    @(posedge clock); #1;
    reset = 1'b0;
    dir_ready = 1'b1;
    dir_op = OPC_JAL;
    #1;
    check("jal_fetch_ir_write", ir_write, 1);
    @(posedge clock); #1;
    dir_ready = 1'b0;
    @(posedge clock); #1;
    check("jal_regwrite", regwrite, 1);
    check("jal_regdst", regdst, 2'b10);
    check("jal_memtoreg", memtoreg, 2'b10);
    check("jal_pcsource", pcsource, 2'b10);
    check("jal_pc_en", pc_en, 1);
    @(posedge clock); #1;
    check("stall_mem_req", mem_req, 1);
    check("jal_retired", instr_count, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("reset_drops_mem_req", mem_req, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("post_reset_count", instr_count, 0);
    check("post_reset_err", err, 0);
    check("post_reset_fetch", mem_req, 1);

    dir_ready = 1'b1;
    dir_op = OPC_ORI;
    @(posedge clock); #1;
    dir_ready = 1'b0;
    @(posedge clock); #1;
    check("noext_ori_illegal", illegal2, 1);
    check("noext_ori_regwrite", regwrite2, 0);
    check("noext_ori_pc_en", pc_en2, 0);
    check("ext_ori_zero_ext", zero_ext, 1);
    check("ext_ori_not_illegal", illegal, 0);
    @(posedge clock); #1;
    check("noext_illegal_pulse", illegal2, 0);
    check("noext_back_fetch", mem_req2, 1);
    check("noext_count", instr_count2, 0);
    check("ext_ori_wb", regwrite, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
